// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_port_ctrl
// Description : Memory-mapped board I/O block. Synchronizes switches and keys,
//               debounces keys with sticky press events, and drives LEDs and
//               six seven-segment displays from CPU-writable registers.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_we,
   output logic [31:0] io_rdata,
   input  logic [9:0]  sw,
   input  logic [3:1]  key,
   output logic [6:0]  hex5,
   output logic [6:0]  hex4,
   output logic [6:0]  hex3,
   output logic [6:0]  hex2,
   output logic [6:0]  hex1,
   output logic [6:0]  hex0,
   output logic [9:0]  led
);

   // Counter value on which the next differing cycle commits the new level
   localparam logic [15:0] C_DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] C_OFS_SW    = 3'd0;
   localparam logic [2:0] C_OFS_KEY   = 3'd1;
   localparam logic [2:0] C_OFS_EVT   = 3'd2;
   localparam logic [2:0] C_OFS_LED   = 3'd3;
   localparam logic [2:0] C_OFS_HEX   = 3'd4;
   localparam logic [2:0] C_OFS_BLANK = 3'd5;

   logic [9:0]  r_sw_meta, r_sw_sync;
   logic [3:1]  r_key_meta, r_key_sync;
   logic [3:1]  r_stable;
   logic [15:0] r_cnt [3:1];
   logic [3:1]  r_evt;
   logic [9:0]  r_led;
   logic [23:0] r_hex;
   logic [5:0]  r_blank;

   logic [3:1]  w_pressed;
   logic [3:1]  w_diff;
   logic [3:1]  w_commit;
   logic [3:1]  w_rise;
   logic [3:1]  w_evt_clr;
   logic [2:0]  w_ofs;
   logic [6:0]  w_hex [6];

   assign w_ofs     = io_addr[4:2];
   assign w_pressed = ~r_key_sync;

   // Two-flop synchronizers; keys reset to the released (high) level
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_key_meta <= '1;
         r_key_sync <= '1;
      end else begin
         r_sw_meta  <= sw;
         r_sw_sync  <= r_sw_meta;
         r_key_meta <= key;
         r_key_sync <= r_key_meta;
      end
   end

   // Per-key commit decision: the new level must differ for DEBOUNCE_CYCLES cycles
   always_comb begin
      w_diff   = '0;
      w_commit = '0;
      for (int k = 1; k <= 3; k++) begin
         w_diff[k]   = (w_pressed[k] != r_stable[k]);
         w_commit[k] = w_diff[k] && (r_cnt[k] == C_DEB_LAST);
      end
   end

   assign w_rise    = w_commit & w_pressed;
   assign w_evt_clr = (io_we && (w_ofs == C_OFS_EVT)) ? io_wdata[3:1] : 3'b000;

   // Debounce counters and stable pressed levels
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_stable <= '0;
         for (int k = 1; k <= 3; k++) r_cnt[k] <= '0;
      end else begin
         for (int k = 1; k <= 3; k++) begin
            if (!w_diff[k]) begin
               r_cnt[k] <= '0;
            end else if (w_commit[k]) begin
               r_cnt[k]    <= '0;
               r_stable[k] <= w_pressed[k];
            end else begin
               r_cnt[k] <= r_cnt[k] + 16'd1;
            end
         end
      end
   end

   // Sticky press events; a new press wins over a simultaneous clear
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_evt <= '0;
      else         r_evt <= (r_evt & ~w_evt_clr) | w_rise;
   end

   // CPU-writable output registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_led   <= '0;
         r_hex   <= '0;
         r_blank <= '1;
      end else if (io_we) begin
         if (w_ofs == C_OFS_LED)   r_led   <= io_wdata[9:0];
         if (w_ofs == C_OFS_HEX)   r_hex   <= io_wdata[23:0];
         if (w_ofs == C_OFS_BLANK) r_blank <= io_wdata[5:0];
      end
   end

   // Combinational read mux; unmapped offsets and unused bits read as zero
   always_comb begin
      io_rdata = '0;
      case (w_ofs)
         C_OFS_SW:    io_rdata[9:0]  = r_sw_sync;
         C_OFS_KEY:   io_rdata[3:1]  = r_stable;
         C_OFS_EVT:   io_rdata[3:1]  = r_evt;
         C_OFS_LED:   io_rdata[9:0]  = r_led;
         C_OFS_HEX:   io_rdata[23:0] = r_hex;
         C_OFS_BLANK: io_rdata[5:0]  = r_blank;
         default:     io_rdata       = '0;
      endcase
   end

   // Active-low segment pattern, bit0 = a .. bit6 = g
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   for (genvar n = 0; n < 6; n++) begin : g_hex
      assign w_hex[n] = r_blank[n] ? 7'b1111111 : seg_decode(r_hex[4*n +: 4]);
   end

   assign hex0 = w_hex[0];
   assign hex1 = w_hex[1];
   assign hex2 = w_hex[2];
   assign hex3 = w_hex[3];
   assign hex4 = w_hex[4];
   assign hex5 = w_hex[5];
   assign led  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_ctrl
// Description : Directed self-checking bench for io_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;

   logic        clock;
   logic        resetn;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic        io_we;
   logic [31:0] io_rdata;
   logic [9:0]  sw;
   logic [3:1]  key;
   logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
   logic [9:0]  led;
   logic [41:0] hex_all;

   int checks   = 0;
   int failures = 0;

   io_port_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_we    (io_we),
      .io_rdata (io_rdata),
      .sw       (sw),
      .key      (key),
      .hex5     (hex5),
      .hex4     (hex4),
      .hex3     (hex3),
      .hex2     (hex2),
      .hex1     (hex1),
      .hex0     (hex0),
      .led      (led)
   );

   assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single store cycle: drive on the falling edge, commit on the rising edge
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      io_addr  = a;
      io_wdata = d;
      io_we    = 1'b1;
      @(posedge clock);
      #1;
      io_we    = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (led !== 10'h000) begin
         failures++; $display("FAIL reset_led got=%h exp=%h", led, 10'h000);
      end
      checks++;
      if (hex_all !== {42{1'b1}}) begin
         failures++; $display("FAIL reset_hex got=%h exp=%h", hex_all, {42{1'b1}});
      end
      io_addr = 32'h0; #1;
      checks++;
      if (io_rdata !== 32'h0) begin
         failures++; $display("FAIL reset_sw got=%h exp=%h", io_rdata, 32'h0);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (io_rdata !== 32'h0) begin
         failures++; $display("FAIL sw_edge1 got=%h exp=%h", io_rdata, 32'h0);
      end
      @(posedge clock); #1;
      checks++;
      if (io_rdata !== 32'h2AA) begin
         failures++; $display("FAIL sw_edge2 got=%h exp=%h", io_rdata, 32'h2AA);
      end
   endtask

   task automatic test_hex;
      do_write(32'h10, 32'h0012_3456);
      checks++;
      if (hex_all !== {42{1'b1}}) begin
         failures++; $display("FAIL hex_still_blank got=%h exp=%h", hex_all, {42{1'b1}});
      end
      io_addr = 32'h10; #1;
      checks++;
      if (io_rdata !== 32'h0012_3456) begin
         failures++; $display("FAIL hex_read got=%h exp=%h", io_rdata, 32'h0012_3456);
      end
      do_write(32'h14, 32'h0);
      checks++;
      if (hex_all !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}) begin
         failures++; $display("FAIL hex_123456 got=%h", hex_all);
      end
      do_write(32'h14, 32'h1);
      checks++;
      if (hex_all !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b1111111}) begin
         failures++; $display("FAIL hex_blank0 got=%h", hex_all);
      end
      do_write(32'h14, 32'h0);
      do_write(32'h10, 32'h00AB_CDEF);
      checks++;
      if (hex_all !== {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}) begin
         failures++; $display("FAIL hex_abcdef got=%h", hex_all);
      end
      do_write(32'h10, 32'hFF78_9000);
      checks++;
      if (hex_all !== {7'b1111000, 7'b0000000, 7'b0010000, 7'b1000000, 7'b1000000, 7'b1000000}) begin
         failures++; $display("FAIL hex_789000 got=%h", hex_all);
      end
      io_addr = 32'h10; #1;
      checks++;
      if (io_rdata !== 32'h0078_9000) begin
         failures++; $display("FAIL hex_read_trunc got=%h exp=%h", io_rdata, 32'h0078_9000);
      end
   endtask

   task automatic test_key_debounce;
      @(negedge clock);
      key = 3'b110;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clock); #1;
         io_addr = 32'h4; #1;
         checks++;
         if (io_rdata !== ((i >= 6) ? 32'h2 : 32'h0)) begin
            failures++; $display("FAIL key1_press edge=%0d got=%h exp=%h", i, io_rdata, (i >= 6) ? 32'h2 : 32'h0);
         end
         io_addr = 32'h8; #1;
         checks++;
         if (io_rdata !== ((i >= 6) ? 32'h2 : 32'h0)) begin
            failures++; $display("FAIL evt1_press edge=%0d got=%h exp=%h", i, io_rdata, (i >= 6) ? 32'h2 : 32'h0);
         end
      end
      @(negedge clock);
      key = 3'b111;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clock); #1;
         io_addr = 32'h4; #1;
         checks++;
         if (io_rdata !== ((i >= 6) ? 32'h0 : 32'h2)) begin
            failures++; $display("FAIL key1_release edge=%0d got=%h exp=%h", i, io_rdata, (i >= 6) ? 32'h0 : 32'h2);
         end
         io_addr = 32'h8; #1;
         checks++;
         if (io_rdata !== 32'h2) begin
            failures++; $display("FAIL evt1_release edge=%0d got=%h exp=%h", i, io_rdata, 32'h2);
         end
      end
      do_write(32'h8, 32'h2);
      io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h0) begin
         failures++; $display("FAIL evt1_clear got=%h exp=%h", io_rdata, 32'h0);
      end
   endtask

   task automatic test_glitch;
      @(negedge clock);
      key = 3'b101;
      repeat (3) @(posedge clock);
      @(negedge clock);
      key = 3'b111;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clock); #1;
         io_addr = 32'h4; #1;
         checks++;
         if (io_rdata !== 32'h0) begin
            failures++; $display("FAIL glitch_key edge=%0d got=%h exp=%h", i, io_rdata, 32'h0);
         end
         io_addr = 32'h8; #1;
         checks++;
         if (io_rdata !== 32'h0) begin
            failures++; $display("FAIL glitch_evt edge=%0d got=%h exp=%h", i, io_rdata, 32'h0);
         end
      end
   endtask

   task automatic test_evt_w1c;
      @(negedge clock);
      key = 3'b100;
      repeat (6) @(posedge clock);
      #1; io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h6) begin
         failures++; $display("FAIL evt_12 got=%h exp=%h", io_rdata, 32'h6);
      end
      do_write(32'h8, 32'h4);
      io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h2) begin
         failures++; $display("FAIL evt_w1c got=%h exp=%h", io_rdata, 32'h2);
      end
      @(negedge clock);
      key = 3'b000;
      repeat (5) @(posedge clock);
      #1; io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h2) begin
         failures++; $display("FAIL evt3_early got=%h exp=%h", io_rdata, 32'h2);
      end
      do_write(32'h8, 32'h8);
      io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'hA) begin
         failures++; $display("FAIL evt3_set_wins got=%h exp=%h", io_rdata, 32'hA);
      end
      io_addr = 32'h4; #1;
      checks++;
      if (io_rdata !== 32'hE) begin
         failures++; $display("FAIL key_all got=%h exp=%h", io_rdata, 32'hE);
      end
      do_write(32'h8, 32'h8);
      io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h2) begin
         failures++; $display("FAIL evt3_clear got=%h exp=%h", io_rdata, 32'h2);
      end
      @(negedge clock);
      key = 3'b111;
      repeat (8) @(posedge clock);
      #1; io_addr = 32'h8; #1;
      checks++;
      if (io_rdata !== 32'h2) begin
         failures++; $display("FAIL evt_after_release got=%h exp=%h", io_rdata, 32'h2);
      end
      do_write(32'h8, 32'hFFFF_FFFF);
   endtask

   task automatic test_led;
      do_write(32'hC, 32'hFFFF_FFFF);
      checks++;
      if (led !== 10'h3FF) begin
         failures++; $display("FAIL led_all got=%h exp=%h", led, 10'h3FF);
      end
      io_addr = 32'hC; #1;
      checks++;
      if (io_rdata !== 32'h3FF) begin
         failures++; $display("FAIL led_read got=%h exp=%h", io_rdata, 32'h3FF);
      end
      do_write(32'hC, 32'h155);
      checks++;
      if (led !== 10'h155) begin
         failures++; $display("FAIL led_155 got=%h exp=%h", led, 10'h155);
      end
      do_write(32'h1C, 32'hFFFF_FFFF);
      io_addr = 32'h1C; #1;
      checks++;
      if (io_rdata !== 32'h0) begin
         failures++; $display("FAIL ofs7_read got=%h exp=%h", io_rdata, 32'h0);
      end
      io_addr = 32'h18; #1;
      checks++;
      if (io_rdata !== 32'h0) begin
         failures++; $display("FAIL ofs6_read got=%h exp=%h", io_rdata, 32'h0);
      end
      do_write(32'h0, 32'h0);
      io_addr = 32'h0; #1;
      checks++;
      if (io_rdata !== 32'h2AA) begin
         failures++; $display("FAIL sw_ro got=%h exp=%h", io_rdata, 32'h2AA);
      end
      checks++;
      if (led !== 10'h155) begin
         failures++; $display("FAIL led_hold got=%h exp=%h", led, 10'h155);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clock);
      key = 3'b110;
      repeat (3) @(posedge clock);
      @(negedge clock);
      resetn = 1'b0;
      #1;
      checks++;
      if (led !== 10'h000) begin
         failures++; $display("FAIL async_reset_led got=%h exp=%h", led, 10'h000);
      end
      checks++;
      if (hex_all !== {42{1'b1}}) begin
         failures++; $display("FAIL async_reset_hex got=%h exp=%h", hex_all, {42{1'b1}});
      end
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clock); #1;
         io_addr = 32'h4; #1;
         checks++;
         if (io_rdata !== ((i >= 6) ? 32'h2 : 32'h0)) begin
            failures++; $display("FAIL post_reset_key edge=%0d got=%h exp=%h", i, io_rdata, (i >= 6) ? 32'h2 : 32'h0);
         end
         io_addr = 32'h8; #1;
         checks++;
         if (io_rdata !== ((i >= 6) ? 32'h2 : 32'h0)) begin
            failures++; $display("FAIL post_reset_evt edge=%0d got=%h exp=%h", i, io_rdata, (i >= 6) ? 32'h2 : 32'h0);
         end
      end
      checks++;
      if (led !== 10'h000) begin
         failures++; $display("FAIL post_reset_led got=%h exp=%h", led, 10'h000);
      end
      @(negedge clock);
      key = 3'b111;
   endtask

   initial begin
      resetn   = 1'b0;
      io_addr  = '0;
      io_wdata = '0;
      io_we    = 1'b0;
      sw       = 10'b1010101010;
      key      = 3'b111;
      test_reset();
      test_hex();
      test_key_debounce();
      test_glitch();
      test_evt_w1c();
      test_led();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
